// File: rtl/canvas_access_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : canvas_access_scheduler_if
//  Description : Bundles the engine access channel and the cell-memory port
//                served by canvas_access_scheduler.
//                  eng_req/eng_we/eng_addr/eng_wdata : engine -> scheduler
//                  eng_gnt/eng_rvalid/eng_rdata      : scheduler -> engine
//                  mem_en/mem_we/mem_addr/mem_wdata  : scheduler -> memory
//                  mem_rdata                         : memory -> scheduler
//                The slave modport is the scheduler side; the master modport
//                is the environment side (engine plus memory).
//  Revision    : 1.0  initial release
// ============================================================================
interface canvas_access_scheduler_if #(
  parameter int ADDR_W = 13
) ();

  // Engine access channel
  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_wdata;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic              eng_rdata;

  // Cell-memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wdata;
  logic              mem_rdata;

  modport master (
    output eng_req, eng_we, eng_addr, eng_wdata,
    input  eng_gnt, eng_rvalid, eng_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  eng_req, eng_we, eng_addr, eng_wdata,
    output eng_gnt, eng_rvalid, eng_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/canvas_access_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : canvas_access_scheduler
//  Description : Arbitrates the single read/write port of the Game-of-Life
//                cell memory between canvas clear sweeps, cursor pixel draws
//                and the generation-update engine.
//                Priority: pending clear > pending draw > engine request.
//  Ports       : clk         system clock
//                rst_n       asynchronous active-low reset
//                clear_req   single-cycle request for a full-canvas clear
//                draw_req    single-cycle request to set the cell under
//                            (draw_x, draw_y)
//                draw_x/y    pixel coordinates of the draw request
//                clear_busy  a clear write is on the memory port
//                clear_done  one-cycle pulse after the last clear write
//                draw_drop   one-cycle pulse: out-of-range draw discarded
//                bus         engine channel and memory port (slave side)
//  Revision    : 1.0  initial release
// ============================================================================
module canvas_access_scheduler #(
  parameter int GRID_W     = 80,
  parameter int GRID_H     = 60,
  parameter int CELL_SHIFT = 3,
  parameter int ADDR_W     = 13
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       clear_req,
  input  wire logic       draw_req,
  input  wire logic [9:0] draw_x,
  input  wire logic [8:0] draw_y,
  output logic            clear_busy,
  output logic            clear_done,
  output logic            draw_drop,
  canvas_access_scheduler_if.slave bus
);

  localparam logic [31:0]       c_PIX_W     = 32'(GRID_W << CELL_SHIFT);
  localparam logic [31:0]       c_PIX_H     = 32'(GRID_H << CELL_SHIFT);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_clear_pend;
  logic [ADDR_W-1:0] r_sweep_addr;
  logic              r_draw_pend;
  logic [9:0]        r_draw_cx;
  logic [8:0]        r_draw_cy;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_wdata;
  logic              r_mem_eng_rd;
  logic              r_eng_rvalid;

  logic              r_clear_busy;
  logic              r_clear_last;
  logic              r_clear_done;
  logic              r_draw_drop;

  logic              w_clear_win;
  logic              w_draw_win;
  logic              w_eng_win;
  logic              w_sweep_issue;
  logic              w_sweep_last;
  logic              w_draw_in_range;
  logic [ADDR_W-1:0] w_draw_addr;

  assign w_draw_in_range = (32'(draw_x) < c_PIX_W) && (32'(draw_y) < c_PIX_H);

  // Cell address of the latched draw: cy * GRID_W + cx.
  if (GRID_W == 80) begin : g_addr_shift_add
    // 80 = 64 + 16
    assign w_draw_addr = (ADDR_W'(r_draw_cy) << 6) + (ADDR_W'(r_draw_cy) << 4)
                       + ADDR_W'(r_draw_cx);
  end else begin : g_addr_generic
    assign w_draw_addr = ADDR_W'(32'(r_draw_cy) * 32'(GRID_W) + 32'(r_draw_cx));
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and per-cycle arbitration decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_clear_win   = 1'b0;
    w_draw_win    = 1'b0;
    w_eng_win     = 1'b0;
    w_sweep_issue = 1'b0;
    w_sweep_last  = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (r_clear_pend) begin
          w_clear_win = 1'b1;
          w_state_nxt = ST_CLEAR;
        end else if (r_draw_pend) begin
          w_draw_win = 1'b1;
        end else if (bus.eng_req) begin
          w_eng_win = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_sweep_issue = 1'b1;
        if (r_sweep_addr == c_LAST_ADDR) begin
          w_sweep_last = 1'b1;
          w_state_nxt  = ST_ARB;
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture and sweep counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // A pending clear out of reset wipes the canvas after every reset.
      r_clear_pend <= 1'b1;
      r_sweep_addr <= '0;
      r_draw_pend  <= 1'b0;
      r_draw_cx    <= '0;
      r_draw_cy    <= '0;
      r_draw_drop  <= 1'b0;
    end else begin
      // A new request in the same cycle the old one is serviced re-arms it.
      if (clear_req) begin
        r_clear_pend <= 1'b1;
      end else if (w_clear_win) begin
        r_clear_pend <= 1'b0;
      end

      if (w_clear_win) begin
        r_sweep_addr <= '0;
      end else if (w_sweep_issue) begin
        r_sweep_addr <= r_sweep_addr + ADDR_W'(1);
      end

      // Cell coordinates are latched rather than pixels; a later in-range
      // draw simply overwrites an unserviced one.
      if (draw_req && w_draw_in_range) begin
        r_draw_pend <= 1'b1;
        r_draw_cx   <= draw_x >> CELL_SHIFT;
        r_draw_cy   <= draw_y >> CELL_SHIFT;
      end else if (w_draw_win) begin
        r_draw_pend <= 1'b0;
      end

      r_draw_drop <= draw_req && !w_draw_in_range;
    end
  end

  // --------------------------------------------------------------------------
  // Registered memory port and status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 1'b0;
      r_mem_eng_rd <= 1'b0;
      r_eng_rvalid <= 1'b0;
      r_clear_busy <= 1'b0;
      r_clear_last <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_eng_rd <= 1'b0;
      if (w_sweep_issue) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_sweep_addr;
        r_mem_wdata <= 1'b0;
      end else if (w_draw_win) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= w_draw_addr;
        r_mem_wdata <= 1'b1;
      end else if (w_eng_win) begin
        r_mem_en     <= 1'b1;
        r_mem_we     <= bus.eng_we;
        r_mem_addr   <= bus.eng_addr;
        r_mem_wdata  <= bus.eng_wdata;
        r_mem_eng_rd <= !bus.eng_we;
      end

      // Memory returns read data one cycle after the access is on the port.
      r_eng_rvalid <= r_mem_eng_rd;

      // busy/last travel with the write they describe; done trails by one.
      r_clear_busy <= w_sweep_issue;
      r_clear_last <= w_sweep_last;
      r_clear_done <= r_clear_last;
    end
  end

  assign bus.eng_gnt    = w_eng_win;
  assign bus.eng_rvalid = r_eng_rvalid;
  assign bus.eng_rdata  = bus.mem_rdata;
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

  assign clear_busy = r_clear_busy;
  assign clear_done = r_clear_done;
  assign draw_drop  = r_draw_drop;

endmodule
`default_nettype wire

// File: tb/tb_canvas_access_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_canvas_access_scheduler
//  Description : Directed self-checking bench for canvas_access_scheduler.
//                Inputs change 1 ns after the rising edge; outputs are
//                sampled on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_canvas_access_scheduler;

  localparam int ADDR_W = 13;
  localparam int CELLS  = 4800;

  logic       clk;
  logic       rst_n;
  logic       clear_req;
  logic       draw_req;
  logic [9:0] draw_x;
  logic [8:0] draw_y;
  logic       clear_busy;
  logic       clear_done;
  logic       draw_drop;

  int errors = 0;
  int checks = 0;

  canvas_access_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  canvas_access_scheduler #(
    .GRID_W    (80),
    .GRID_H    (60),
    .CELL_SHIFT(3),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .draw_req  (draw_req),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .draw_drop (draw_drop),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Waits up to exp_lat+8 cycles for the first sweep write, checks it arrives
  // exactly exp_lat cycles after the current cycle, then checks all CELLS
  // writes. Returns at the sample point of the last sweep write.
  task automatic check_sweep(input int exp_lat);
    int lat;
    lat = -1;
    for (int c = 0; c < exp_lat + 8; c++) begin
      smp();
      if (bus.mem_en === 1'b1) begin
        lat = c;
        break;
      end
      cyc();
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL sweep_latency: got %0d cycles, expected %0d", lat, exp_lat);
    end
    if (lat >= 0) begin
      for (int a = 0; a < CELLS; a++) begin
        if (a != 0) begin
          cyc();
          smp();
        end
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 1'b0 ||
            bus.mem_addr !== ADDR_W'(a) || clear_busy !== 1'b1 ||
            clear_done !== 1'b0 || bus.eng_gnt !== 1'b0) begin
          errors++;
          $display("FAIL sweep_write: en=%b we=%b addr=%0d wdata=%b busy=%b done=%b gnt=%b, expected en=1 we=1 addr=%0d wdata=0 busy=1 done=0 gnt=0",
                   bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                   clear_busy, clear_done, bus.eng_gnt, a);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.eng_req = 1'b1;
    bus.eng_addr = 13'd5;
    cyc();
    cyc();
    smp();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mem: en=%b we=%b addr=%0d wdata=%b, expected all 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if ({bus.eng_gnt, bus.eng_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_eng: gnt=%b rvalid=%b, expected 0 0", bus.eng_gnt, bus.eng_rvalid);
    end
    checks++;
    if ({clear_busy, clear_done, draw_drop} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b drop=%b, expected 0 0 0",
               clear_busy, clear_done, draw_drop);
    end
  endtask

  task automatic test_post_reset_clear();
    cyc();
    bus.eng_req = 1'b0;
    rst_n = 1'b1;
    check_sweep(2);
    cyc();
    smp();
    checks++;
    if ({clear_done, clear_busy, bus.mem_en} !== 3'b100) begin
      errors++;
      $display("FAIL clear_done_pulse: done=%b busy=%b en=%b, expected 1 0 0",
               clear_done, clear_busy, bus.mem_en);
    end
    cyc();
    smp();
    checks++;
    if (clear_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_width: done=%b, expected 0", clear_done);
    end
  endtask

  task automatic test_draw();
    cyc();
    draw_req = 1'b1;
    draw_x = 10'd17;
    draw_y = 9'd9;
    smp();
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL draw_c0: en=%b, expected 0", bus.mem_en);
    end
    cyc();
    draw_req = 1'b0;
    smp();
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL draw_c1: en=%b, expected 0", bus.mem_en);
    end
    cyc();
    smp();
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 13'd82 ||
        bus.mem_wdata !== 1'b1) begin
      errors++;
      $display("FAIL draw_write: en=%b we=%b addr=%0d wdata=%b, expected 1 1 82 1",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc();
    smp();
    checks++;
    if ({bus.mem_en, bus.eng_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL draw_single: en=%b rvalid=%b, expected 0 0", bus.mem_en, bus.eng_rvalid);
    end
  endtask

  task automatic test_engine_read();
    cyc();
    bus.mem_rdata = 1'b1;
    bus.eng_req = 1'b1;
    bus.eng_we = 1'b0;
    bus.eng_wdata = 1'b0;
    bus.eng_addr = 13'd100;
    smp();
    checks++;
    if (bus.eng_gnt !== 1'b1) begin
      errors++;
      $display("FAIL eng_read_gnt: gnt=%b, expected 1", bus.eng_gnt);
    end
    cyc();
    bus.eng_req = 1'b0;
    smp();
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 13'd100 ||
        bus.eng_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL eng_read_access: en=%b we=%b addr=%0d rvalid=%b, expected 1 0 100 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.eng_rvalid);
    end
    cyc();
    smp();
    checks++;
    if ({bus.eng_rvalid, bus.eng_rdata, bus.mem_en} !== 3'b110) begin
      errors++;
      $display("FAIL eng_read_data: rvalid=%b rdata=%b en=%b, expected 1 1 0",
               bus.eng_rvalid, bus.eng_rdata, bus.mem_en);
    end
    cyc();
    bus.mem_rdata = 1'b0;
    smp();
    checks++;
    if (bus.eng_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL eng_read_rvalid_width: rvalid=%b, expected 0", bus.eng_rvalid);
    end
  endtask

  task automatic test_engine_write();
    cyc();
    bus.eng_req = 1'b1;
    bus.eng_we = 1'b1;
    bus.eng_wdata = 1'b1;
    bus.eng_addr = 13'd200;
    smp();
    checks++;
    if (bus.eng_gnt !== 1'b1) begin
      errors++;
      $display("FAIL eng_write_gnt: gnt=%b, expected 1", bus.eng_gnt);
    end
    cyc();
    bus.eng_req = 1'b0;
    bus.eng_we = 1'b0;
    bus.eng_wdata = 1'b0;
    smp();
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 13'd200 ||
        bus.mem_wdata !== 1'b1) begin
      errors++;
      $display("FAIL eng_write_access: en=%b we=%b addr=%0d wdata=%b, expected 1 1 200 1",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc();
    smp();
    checks++;
    if (bus.eng_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL eng_write_no_rvalid: rvalid=%b, expected 0", bus.eng_rvalid);
    end
  endtask

  // Streaming reads 10,11,12 with a corner draw landing in the middle.
  task automatic test_back_to_back();
    cyc();
    bus.eng_req = 1'b1;
    bus.eng_we = 1'b0;
    bus.eng_addr = 13'd10;
    draw_req = 1'b1;
    draw_x = 10'd639;
    draw_y = 9'd479;
    smp();
    checks++;
    if (bus.eng_gnt !== 1'b1) begin
      errors++;
      $display("FAIL b2b_c0_gnt: gnt=%b, expected 1", bus.eng_gnt);
    end
    cyc();
    draw_req = 1'b0;
    bus.eng_addr = 13'd11;
    smp();
    checks++;
    if (bus.eng_gnt !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 ||
        bus.mem_addr !== 13'd10) begin
      errors++;
      $display("FAIL b2b_c1: gnt=%b en=%b we=%b addr=%0d, expected 0 1 0 10",
               bus.eng_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    cyc();
    smp();
    checks++;
    if (bus.eng_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== 13'd4799 || bus.mem_wdata !== 1'b1 || bus.eng_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_c2: gnt=%b en=%b we=%b addr=%0d wdata=%b rvalid=%b, expected 1 1 1 4799 1 1",
               bus.eng_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.eng_rvalid);
    end
    cyc();
    bus.eng_addr = 13'd12;
    smp();
    checks++;
    if (bus.eng_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 13'd11 ||
        bus.eng_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_c3: gnt=%b we=%b addr=%0d rvalid=%b, expected 1 0 11 0",
               bus.eng_gnt, bus.mem_we, bus.mem_addr, bus.eng_rvalid);
    end
    cyc();
    bus.eng_req = 1'b0;
    smp();
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 13'd12 || bus.eng_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_c4: en=%b addr=%0d rvalid=%b, expected 1 12 1",
               bus.mem_en, bus.mem_addr, bus.eng_rvalid);
    end
    cyc();
    smp();
    checks++;
    if ({bus.mem_en, bus.eng_rvalid} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_c5: en=%b rvalid=%b, expected 0 1", bus.mem_en, bus.eng_rvalid);
    end
  endtask

  task automatic test_clear_during_stream();
    cyc();
    bus.eng_req = 1'b1;
    bus.eng_we = 1'b0;
    bus.eng_addr = 13'd20;
    clear_req = 1'b1;
    smp();
    checks++;
    if (bus.eng_gnt !== 1'b1) begin
      errors++;
      $display("FAIL cls_c0_gnt: gnt=%b, expected 1", bus.eng_gnt);
    end
    cyc();
    clear_req = 1'b0;
    bus.eng_addr = 13'd21;
    smp();
    checks++;
    if (bus.eng_gnt !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 13'd20) begin
      errors++;
      $display("FAIL cls_c1: gnt=%b en=%b addr=%0d, expected 0 1 20",
               bus.eng_gnt, bus.mem_en, bus.mem_addr);
    end
    cyc();
    draw_req = 1'b1;
    draw_x = 10'd0;
    draw_y = 9'd0;
    smp();
    checks++;
    if (bus.eng_gnt !== 1'b0 || bus.mem_en !== 1'b0 || bus.eng_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL cls_c2: gnt=%b en=%b rvalid=%b, expected 0 0 1",
               bus.eng_gnt, bus.mem_en, bus.eng_rvalid);
    end
    cyc();
    draw_req = 1'b0;
    check_sweep(0);
    cyc();
    smp();
    checks++;
    if (clear_done !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== 13'd0 || bus.mem_wdata !== 1'b1 || bus.eng_gnt !== 1'b1) begin
      errors++;
      $display("FAIL cls_after: done=%b en=%b we=%b addr=%0d wdata=%b gnt=%b, expected 1 1 1 0 1 1",
               clear_done, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.eng_gnt);
    end
    cyc();
    bus.eng_req = 1'b0;
    smp();
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 13'd21 ||
        clear_done !== 1'b0) begin
      errors++;
      $display("FAIL cls_resume: en=%b we=%b addr=%0d done=%b, expected 1 0 21 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, clear_done);
    end
  endtask

  task automatic test_draw_drop();
    cyc();
    cyc();
    draw_req = 1'b1;
    draw_x = 10'd640;
    draw_y = 9'd5;
    smp();
    checks++;
    if (draw_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_x_c0: drop=%b, expected 0", draw_drop);
    end
    cyc();
    draw_req = 1'b0;
    smp();
    checks++;
    if ({draw_drop, bus.mem_en} !== 2'b10) begin
      errors++;
      $display("FAIL drop_x_c1: drop=%b en=%b, expected 1 0", draw_drop, bus.mem_en);
    end
    cyc();
    draw_req = 1'b1;
    draw_x = 10'd0;
    draw_y = 9'd480;
    smp();
    checks++;
    if ({draw_drop, bus.mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL drop_x_c2: drop=%b en=%b, expected 0 0", draw_drop, bus.mem_en);
    end
    cyc();
    draw_req = 1'b0;
    smp();
    checks++;
    if ({draw_drop, bus.mem_en} !== 2'b10) begin
      errors++;
      $display("FAIL drop_y_c1: drop=%b en=%b, expected 1 0", draw_drop, bus.mem_en);
    end
    cyc();
    smp();
    checks++;
    if ({draw_drop, bus.mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL drop_y_c2: drop=%b en=%b, expected 0 0", draw_drop, bus.mem_en);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit found;
    found = 1'b0;
    cyc();
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    for (int c = 0; c < 2200; c++) begin
      smp();
      if (bus.mem_en === 1'b1 && bus.mem_addr === 13'd2000) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midsweep_reach: sweep address 2000 seen=%b, expected 1", found);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_en, clear_busy, bus.mem_addr} !== 15'h0) begin
      errors++;
      $display("FAIL midsweep_abort: en=%b busy=%b addr=%0d, expected 0 0 0",
               bus.mem_en, clear_busy, bus.mem_addr);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_sweep(2);
    cyc();
    smp();
    checks++;
    if ({clear_done, clear_busy} !== 2'b10) begin
      errors++;
      $display("FAIL midsweep_done: done=%b busy=%b, expected 1 0", clear_done, clear_busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_req = 1'b0;
    draw_req = 1'b0;
    draw_x = '0;
    draw_y = '0;
    bus.eng_req = 1'b0;
    bus.eng_we = 1'b0;
    bus.eng_addr = '0;
    bus.eng_wdata = 1'b0;
    bus.mem_rdata = 1'b0;

    test_reset();
    test_post_reset_clear();
    test_draw();
    test_engine_read();
    test_engine_write();
    test_back_to_back();
    test_clear_during_stream();
    test_draw_drop();
    test_reset_mid_sweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
